// File: rtl/pair_triple_stim_gen.sv
// ============================================================================
// Module: pair_triple_stim_gen
//
// Purpose
//   On-chip stimulus driver and checker for a 3-input 2-of-3 majority
//   ("pair/triple") detector. It drives every one of the 8 input patterns
//   onto in0/in1/in2 and holds each one for HOLD_CYCLES cycles. On the last
//   cycle of each pattern it samples the detector output and compares it
//   with the majority of the driven pattern. It repeats the sweep
//   NUM_PASSES times. It then reports a saturating mismatch count and the
//   first failing pattern.
//
// Parameters
//   NUM_PASSES   full 8-pattern sweeps per run (>= 1)
//   HOLD_CYCLES  cycles each pattern is held before it is sampled (>= 1)
//   ERR_W        width of the saturating mismatch counter
//
// Ports
//   clk            in   1      clock, rising edge
//   reset          in   1      asynchronous, active-low reset
//   start          in   1      run request, honoured only in IDLE or DONE
//   in0,in1,in2    out  1      pattern driven to the detector (in0 = MSB)
//   dut_out        in   1      detector output, combinational from in*
//   busy           out  1      run in progress
//   done           out  1      run complete, held until the next start
//   err_count      out  ERR_W  mismatch count, saturating
//   first_err_vld  out  1      at least one mismatch seen this run
//   first_err_pat  out  3      {in0,in1,in2} of the first mismatch
//
// Configuration macro
//   PAIR_TRIPLE_STIM_GRAY_EN  when defined, the patterns are swept in Gray
//                             order (000,001,011,010,110,111,101,100).
//                             Otherwise they are swept in binary order.
// ============================================================================
module pair_triple_stim_gen #(
    parameter int NUM_PASSES  = 1,
    parameter int HOLD_CYCLES = 1,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in0,
    output logic             in1,
    output logic             in2,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_vld,
    output logic [2:0]       first_err_pat
);

    // Counter widths. Each counter is at least one bit wide, so that a
    // degenerate parameter value of 1 still gives legal vectors.
    localparam int PASS_W = (NUM_PASSES  > 1) ? $clog2(NUM_PASSES)  : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        idx;
    logic [PASS_W-1:0] pass_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        pat;

    logic              exp_bit;
    logic              sample;
    logic              mismatch;

    // Maps the sweep index to the pattern that is driven. In Gray mode,
    // exactly one detector input toggles between consecutive patterns.
    function automatic logic [2:0] pattern_of(input logic [2:0] i);
`ifdef PAIR_TRIPLE_STIM_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // The pattern register drives the detector directly. Because of this,
    // in* can change only on clock edges and cannot glitch.
    assign in0 = pat[2];
    assign in1 = pat[1];
    assign in2 = pat[0];

    // Reference majority of the pattern currently held. The detector output
    // is compared with this value only on the last hold cycle of a pattern.
    assign exp_bit  = (pat[2] & pat[1]) | (pat[2] & pat[0]) | (pat[1] & pat[0]);
    assign sample   = (hold_cnt == LAST_HOLD);
    assign mismatch = (dut_out != exp_bit);

    // Single sequencing FSM. IDLE and DONE behave the same way on start:
    // both clear the previous result and begin a new sweep from pattern 0.
    // In DRIVE, start is ignored. The sweep advances one pattern per
    // HOLD_CYCLES cycles. It checks the detector on the edge that leaves
    // each pattern and finishes on the last sample of the final pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= 3'd0;
            pass_cnt      <= '0;
            hold_cnt      <= '0;
            pat           <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_pat <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= DRIVE;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        err_count     <= '0;
                        first_err_vld <= 1'b0;
                        first_err_pat <= 3'd0;
                        idx           <= 3'd0;
                        pass_cnt      <= '0;
                        hold_cnt      <= '0;
                        pat           <= pattern_of(3'd0);
                    end
                end

                DRIVE: begin
                    if (sample) begin
                        if (mismatch) begin
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + 1'b1;
                            end
                            if (!first_err_vld) begin
                                first_err_vld <= 1'b1;
                                first_err_pat <= pat;
                            end
                        end
                        hold_cnt <= '0;
                        if (idx == 3'd7) begin
                            idx <= 3'd0;
                            if (pass_cnt == LAST_PASS) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pat   <= 3'd0;
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                                pat      <= pattern_of(3'd0);
                            end
                        end else begin
                            idx <= idx + 3'd1;
                            pat <= pattern_of(idx + 3'd1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pat   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_triple_stim_gen.sv
// ============================================================================
// Testbench: tb_pair_triple_stim_gen
//
// Purpose
//   Exercises pair_triple_stim_gen with NUM_PASSES=2, HOLD_CYCLES=3 and
//   ERR_W=3. It uses a behavioural majority detector whose output can be
//   corrupted per pattern by a fault mask. On non-sample cycles the
//   detector output is replaced with noise, because those cycles must be
//   ignored. Expected pattern streams and run results come from the sweep
//   order and the fault mask. A monitor pops and compares them as the DUT
//   presents them.
//
// Configuration macro
//   PAIR_TRIPLE_STIM_GRAY_EN  selects the Gray sweep order in the model.
// ============================================================================
module tb_pair_triple_stim_gen;

    localparam int NP     = 2;
    localparam int HC     = 3;
    localparam int EW     = 3;
    localparam int RUNCYC = 8 * NP * HC;

    typedef struct {
        int         errs;
        logic       vld;
        logic [2:0] pat;
    } result_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in0, in1, in2;
    logic          dutOut;
    logic          busy, done;
    logic [EW-1:0] errCount;
    logic          firstErrVld;
    logic [2:0]    firstErrPat;

    logic          garbage = 1'b0;
    logic          garbageVal = 1'b0;
    logic [7:0]    faultMask = 8'h00;

`ifdef PAIR_TRIPLE_STIM_GRAY_EN
    logic [2:0] sweepOrder [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
    logic [2:0] sweepOrder [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

    logic [2:0] patQ [$];
    result_t    resQ [$];

    int testsRun = 0;
    int testsFailed = 0;

    event runStarted;

    pair_triple_stim_gen #(
        .NUM_PASSES (NP),
        .HOLD_CYCLES(HC),
        .ERR_W      (EW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in0          (in0),
        .in1          (in1),
        .in2          (in2),
        .dut_out      (dutOut),
        .busy         (busy),
        .done         (done),
        .err_count    (errCount),
        .first_err_vld(firstErrVld),
        .first_err_pat(firstErrPat)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    // A 2-of-3 vote computed by counting ones.
    function automatic logic majority(input logic [2:0] p);
        return (int'(p[0]) + int'(p[1]) + int'(p[2])) >= 2;
    endfunction

    // Behavioural detector. Its output is the majority vote flipped by the
    // fault mask for each pattern, or noise on cycles the DUT must ignore.
    assign dutOut = garbage ? garbageVal
                            : (majority({in0, in1, in2}) ^ faultMask[{in0, in1, in2}]);

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s at time %0t", name, $time);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Expected in* for every busy cycle of one run. Each pattern is held
    // for HC cycles, and the 8-pattern sweep repeats for NP passes.
    task automatic pushPatterns();
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 8; k++)
                for (int h = 0; h < HC; h++)
                    patQ.push_back(sweepOrder[k]);
    endtask

    // Expected result of one run under the current fault mask. Every
    // masked pattern fails once per pass, and the counter clamps at its
    // maximum value. The first failure is the earliest masked pattern in
    // sweep order.
    task automatic pushResult();
        result_t r;
        int ones;
        ones = 0;
        for (int p = 0; p < 8; p++) ones += int'(faultMask[p]);
        r.errs = NP * ones;
        if (r.errs > (1 << EW) - 1) r.errs = (1 << EW) - 1;
        r.vld = 1'b0;
        r.pat = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!r.vld && faultMask[sweepOrder[k]]) begin
                r.vld = 1'b1;
                r.pat = sweepOrder[k];
            end
        end
        resQ.push_back(r);
    endtask

    // Waits for the monitor to consume every expected result. The wait
    // is bounded so that a run that never finishes still ends the bench.
    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget && resQ.size() != 0; i++) @(posedge clk);
        if (resQ.size() != 0) failNow("runTimeout");
        checkOutput("patternsLeft", patQ.size(), 0);
        resQ.delete();
        patQ.delete();
        @(negedge clk);
    endtask

    // Runs once with the given fault mask. It can also pulse start in the
    // middle of the run, and the DUT must ignore that pulse.
    task automatic applyStimulus(input logic [7:0] mask, input bit midStart);
        @(negedge clk);
        faultMask = mask;
        pushPatterns();
        pushResult();
        start = 1'b1;
        @(posedge clk);
        ->runStarted;
        #1 start = 1'b0;
        if (midStart) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitIdle(RUNCYC + 20);
    endtask

    // Holds start high through DONE. A second run must then follow the
    // first back-to-back.
    task automatic applyBackToBack(input logic [7:0] mask);
        @(negedge clk);
        faultMask = mask;
        pushPatterns();
        pushResult();
        pushPatterns();
        pushResult();
        start = 1'b1;
        @(posedge clk);
        ->runStarted;
        repeat (RUNCYC + 1) @(posedge clk);
        ->runStarted;
        #1 start = 1'b0;
        waitIdle(RUNCYC + 20);
    endtask

    // Noise driver. During a run, the detector output is randomised on
    // every cycle that does not end a pattern.
    initial begin
        forever begin
            @(runStarted);
            for (int c = 0; c < RUNCYC; c++) begin
                #1;
                garbage    = ((c + 1) % HC) != 0;
                garbageVal = 1'($urandom_range(0, 1));
                @(posedge clk);
            end
            #1 garbage = 1'b0;
        end
    end

    // Monitor. On every falling edge, it checks the driven pattern against
    // the expected stream. It also checks the reported result on each
    // rising edge of done.
    initial begin
        logic [2:0] expPat;
        result_t    expRes;
        int         busyCycles;
        logic       prevDone;
        busyCycles = 0;
        prevDone   = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busyCycles = 0;
                prevDone   = 1'b0;
            end else begin
                if (busy) begin
                    busyCycles++;
                    if (patQ.size() == 0) begin
                        failNow("patternUnderflow");
                    end else begin
                        expPat = patQ.pop_front();
                        checkOutput("pattern", {in0, in1, in2}, expPat);
                    end
                end else begin
                    checkOutput("idlePattern", {in0, in1, in2}, 0);
                end
                if (done && !prevDone) begin
                    if (resQ.size() == 0) begin
                        failNow("unexpectedDone");
                    end else begin
                        expRes = resQ.pop_front();
                        checkOutput("errCount", errCount, expRes.errs);
                        checkOutput("firstErrVld", firstErrVld, expRes.vld);
                        checkOutput("firstErrPat", firstErrPat, expRes.pat);
                        checkOutput("runLength", busyCycles, RUNCYC);
                        checkOutput("busyAtDone", busy, 0);
                    end
                    busyCycles = 0;
                end
                prevDone = done;
            end
        end
    end

    // Global watchdog against a hung simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence.
    initial begin
        logic [7:0] mask;

        // Check the output values while reset is held.
        #12;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetErr", errCount, 0);
        checkOutput("resetVld", firstErrVld, 0);
        checkOutput("resetPat", {in0, in1, in2}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Good detector.
        applyStimulus(8'h00, 1'b0);

        // Stuck-at-0 detector: every pattern whose majority is 1 fails.
        for (int p = 0; p < 8; p++) mask[p] = majority(3'(p));
        applyStimulus(mask, 1'b0);

        // Fully inverted detector, which saturates the counter. A start
        // pulse in mid-run must be ignored.
        applyStimulus(8'hFF, 1'b1);

        // Random fault masks.
        for (int r = 0; r < 5; r++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // Single-fault masks, which give unsaturated counts.
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h02, 1'b1);

        // Back-to-back runs with start held high.
        applyBackToBack(8'($urandom_range(1, 255)));

        // Reset in the middle of a run.
        @(negedge clk);
        faultMask = 8'hFF;
        pushPatterns();
        start = 1'b1;
        @(posedge clk);
        ->runStarted;
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortErr", errCount, 0);
        checkOutput("abortVld", firstErrVld, 0);
        checkOutput("abortFirstPat", firstErrPat, 0);
        checkOutput("abortPat", {in0, in1, in2}, 0);
        patQ.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (RUNCYC + 5) @(negedge clk);
        checkOutput("postAbortDone", done, 0);
        checkOutput("postAbortBusy", busy, 0);

        // A fresh run after the abort must work normally.
        applyStimulus(8'h10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
